// File: rtl/instruction_memory_loader.sv
// Streams 16-bit instruction words into the byte-wide instruction memory,
// high byte first at even addresses, matching the {mem[PC], mem[PC+1]} fetch.
module instruction_memory_loader #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 16
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [6:0]        WordCount,
  input  logic              InValid,
  input  logic [15:0]       InWord,
  output logic              InReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_WRITE_HI,
    S_WRITE_LO,
    S_FINISH,
    S_FAIL
  } state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [6:0]        rem_q, rem_d;
  logic [15:0]       word_q, word_d;
  logic [ADDR_W:0]   end_addr;

  // One extra bit so a load running past the top cannot wrap to look legal.
  assign end_addr = {1'b0, BaseAddr}
                  + {{(ADDR_W-7){1'b0}}, WordCount, 1'b0};

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          ptr_d = BaseAddr;
          rem_d = WordCount;
          if (BaseAddr[0] || (end_addr > LIMIT)) begin
            state_d = S_FAIL;
          end else if (WordCount == 7'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WAIT_WORD;
          end
        end
      end
      S_WAIT_WORD: begin
        if (InValid) begin
          word_d  = InWord;
          state_d = S_WRITE_HI;
        end
      end
      S_WRITE_HI: state_d = S_WRITE_LO;
      S_WRITE_LO: begin
        ptr_d = ptr_q + ADDR_W'(2);
        rem_d = rem_q - 7'd1;
        if (rem_q == 7'd1) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT_WORD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    InReady = 1'b0;
    MemWe   = 1'b0;
    MemAddr = '0;
    MemData = '0;
    Done    = 1'b0;
    Error   = 1'b0;
    Busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_WAIT_WORD: InReady = 1'b1;
      S_WRITE_HI: begin
        MemWe   = 1'b1;
        MemAddr = ptr_q;
        MemData = word_q[15:8];
      end
      S_WRITE_LO: begin
        MemWe   = 1'b1;
        MemAddr = ptr_q + ADDR_W'(1);
        MemData = word_q[7:0];
      end
      S_FINISH: Done  = 1'b1;
      S_FAIL:   Error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: transaction model of expected byte
// writes, checked every cycle, plus literal expectations per directed load.
module tb_instruction_memory_loader;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [6:0]  WordCount;
  logic        InValid;
  logic [15:0] InWord;
  logic        InReady;
  logic        MemWe;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        Busy;
  logic        Done;
  logic        Error;

  instruction_memory_loader #(.MEM_BYTES(128), .ADDR_W(16)) dut (
    .Clock(clk), .ResetN(rst_n), .Start(Start), .BaseAddr(BaseAddr),
    .WordCount(WordCount), .InValid(InValid), .InWord(InWord),
    .InReady(InReady), .MemWe(MemWe), .MemAddr(MemAddr), .MemData(MemData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int a; int d; int c;} wr_t;

  int  tot = 0;
  int  bad = 0;
  int  ends = 0;
  int  tmo = 0;
  int  test_id = 0;
  bit  fin = 1'b0;
  logic [15:0] wv [64];

  wr_t q[$];
  int  cyc = 0;
  bit  exp_busy = 1'b0;
  bit  start_seen = 1'b0;
  bit  idle_now;
  bit  m_legal = 1'b0;
  bit  t7_done = 1'b0;
  int  m_base, m_cnt, m_acc, m_wr, m_rdy, m_start, m_last_we;
  int  log_a [4];
  int  log_d [4];
  int  log_c [4];
  int  last_a, last_d;

  task automatic chk(input string nm, input int got, input int want);
    tot++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst_n) begin
      chk("rst_inready", int'(InReady), 0);
      chk("rst_we", int'(MemWe), 0);
      chk("rst_addr", int'(MemAddr), 0);
      chk("rst_data", int'(MemData), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_error", int'(Error), 0);
      if (test_id == 7 && !t7_done) begin
        chk("t7_writes_before_rst", m_wr, 3);
        chk("t7_a2", log_a[2], 2);
        chk("t7_d2", log_d[2], 'hAB);
        t7_done = 1'b1;
      end
      exp_busy = 1'b0;
      start_seen = 1'b0;
      m_legal = 1'b0;
      m_cnt = 0;
      m_acc = 0;
      q.delete();
    end else begin
      if (start_seen) exp_busy = 1'b1;
      start_seen = 1'b0;
      idle_now = !exp_busy;
      chk("busy", int'(Busy), int'(exp_busy));
      if (MemWe) begin
        tot++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_we got=%0h/%0h want=none cyc=%0d",
                   MemAddr, MemData, cyc);
        end else begin
          e = q.pop_front();
          chk("wr_addr", int'(MemAddr), e.a);
          chk("wr_data", int'(MemData), e.d);
          chk("wr_cycle", cyc, e.c);
        end
        if (m_wr < 4) begin
          log_a[m_wr] = int'(MemAddr);
          log_d[m_wr] = int'(MemData);
          log_c[m_wr] = cyc;
        end
        last_a = int'(MemAddr);
        last_d = int'(MemData);
        m_wr++;
        m_last_we = cyc;
      end else begin
        chk("idle_addr", int'(MemAddr), 0);
        chk("idle_data", int'(MemData), 0);
        if (q.size() != 0 && q[0].c <= cyc) begin
          chk("missing_write_cycle", cyc, q[0].c);
          void'(q.pop_front());
        end
      end
      if (InReady) begin
        m_rdy++;
        chk("inready_legit",
            int'(exp_busy && m_legal && m_acc < m_cnt && q.size() == 0 &&
                 !MemWe), 1);
        if (InValid) begin
          q.push_back('{m_base + 2*m_acc, int'(InWord[15:8]), cyc + 1});
          q.push_back('{m_base + 2*m_acc + 1, int'(InWord[7:0]), cyc + 2});
          m_acc++;
        end
      end
      if (Done || Error) begin
        chk("end_while_busy", int'(exp_busy), 1);
        chk("done_iff_legal", int'(Done), int'(m_legal));
        chk("error_iff_illegal", int'(Error), int'(!m_legal));
        if (Done) begin
          chk("done_words", m_acc, m_cnt);
          chk("done_q_empty", q.size(), 0);
          chk("done_writes", m_wr, 2*m_cnt);
          if (m_cnt == 0) chk("done_lat0", cyc - m_start, 1);
          else chk("done_after_last_we", cyc, m_last_we + 1);
        end else begin
          chk("error_writes", m_wr, 0);
          chk("error_lat", cyc - m_start, 1);
        end
        case (test_id)
          1, 2: begin
            chk("t12_a0", log_a[0], 0);  chk("t12_d0", log_d[0], 'h12);
            chk("t12_a1", log_a[1], 1);  chk("t12_d1", log_d[1], 'h34);
            chk("t12_a2", log_a[2], 2);  chk("t12_d2", log_d[2], 'hAB);
            chk("t12_a3", log_a[3], 3);  chk("t12_d3", log_d[3], 'hCD);
            chk("t12_lo_follows_hi", log_c[1] - log_c[0], 1);
            if (test_id == 1) begin
              chk("t1_first_we_lat", log_c[0] - m_start, 2);
              chk("t1_gap", log_c[2] - log_c[1], 2);
              chk("t1_done_lat", cyc - m_start, 7);
              chk("t1_ready_cycles", m_rdy, 2);
            end else begin
              chk("t2_done_lat", cyc - m_start, 15);
              chk("t2_ready_cycles", m_rdy, 10);
            end
          end
          3, 4: begin
            chk("t34_error", int'(Error), 1);
            chk("t34_ready_cycles", m_rdy, 0);
          end
          5: begin
            chk("t5_done", int'(Done), 1);
            chk("t5_ready_cycles", m_rdy, 0);
          end
          6: begin
            chk("t6_done", int'(Done), 1);
            chk("t6_last_addr", last_a, 127);
            chk("t6_last_data", last_d, 'h3F);
            chk("t6_writes", m_wr, 128);
            chk("t6_done_lat", cyc - m_start, 193);
          end
          8: begin
            chk("t8_a0", log_a[0], 8);   chk("t8_d0", log_d[0], 'hBE);
            chk("t8_a1", log_a[1], 9);   chk("t8_d1", log_d[1], 'hEF);
            chk("t8_a2", log_a[2], 10);  chk("t8_d2", log_d[2], 'h01);
            chk("t8_last_a", last_a, 13);
            chk("t8_last_d", last_d, 'h80);
            chk("t8_done_lat", cyc - m_start, 10);
          end
          default: ;
        endcase
        ends++;
        exp_busy = 1'b0;
      end
      if (Start && idle_now) begin
        start_seen = 1'b1;
        m_base = int'(BaseAddr);
        m_cnt = int'(WordCount);
        m_legal = (m_base % 2 == 0) && (m_base + 2*m_cnt <= 128);
        m_acc = 0;
        m_wr = 0;
        m_rdy = 0;
        m_start = cyc;
        q.delete();
      end
    end
    if (fin) begin
      chk("no_timeouts", tmo, 0);
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
    end
  end

  task automatic do_load(input logic [15:0] b, input logic [6:0] n,
                         input int gap, input int tid, input bit mid_start,
                         input int nfeed);
    int  e0;
    bit  ok;
    e0 = ends;
    test_id = tid;
    @(posedge clk); #1;
    Start = 1'b1; BaseAddr = b; WordCount = n;
    @(posedge clk); #1;
    Start = 1'b0;
    for (int k = 0; k < nfeed; k++) begin
      if (gap > 0) begin
        InValid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      InValid = 1'b1;
      InWord = wv[k];
      if (mid_start && k == 10) begin
        Start = 1'b1; BaseAddr = 16'd2; WordCount = 7'd1;
      end
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clk);
        ok = InReady;
        @(posedge clk); #1;
      end
      Start = 1'b0;
      if (!ok) tmo++;
    end
    InValid = 1'b0;
    for (int w = 0; w < 400 && ends == e0; w++) @(posedge clk);
    if (ends == e0) tmo++;
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; BaseAddr = '0; WordCount = '0;
    InValid = 1'b0; InWord = '0;
    for (int i = 0; i < 64; i++) wv[i] = 16'(i);
    #22 rst_n = 1'b1;
    wv[0] = 16'h1234; wv[1] = 16'hABCD;
    do_load(16'd0, 7'd2, 0, 1, 1'b0, 2);
    do_load(16'd0, 7'd2, 5, 2, 1'b0, 2);
    do_load(16'd126, 7'd2, 0, 3, 1'b0, 0);
    do_load(16'd3, 7'd1, 0, 4, 1'b0, 0);
    do_load(16'd0, 7'd0, 0, 5, 1'b0, 0);
    for (int i = 0; i < 64; i++) wv[i] = 16'(i);
    do_load(16'd0, 7'd64, 0, 6, 1'b1, 64);
    wv[0] = 16'h1234; wv[1] = 16'hABCD;
    test_id = 7;
    @(posedge clk); #1;
    Start = 1'b1; BaseAddr = 16'd0; WordCount = 7'd2;
    @(posedge clk); #1;
    Start = 1'b0; InValid = 1'b1; InWord = wv[0];
    @(posedge clk); #1;
    InWord = wv[1];
    repeat (3) @(posedge clk);
    #1 InValid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wv[0] = 16'hBEEF; wv[1] = 16'h0102; wv[2] = 16'h7F80;
    do_load(16'd8, 7'd3, 0, 8, 1'b0, 3);
    repeat (3) @(posedge clk);
    fin = 1'b1;
  end

endmodule
